dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Initiator side of the data-memory port: sits between the CPU load/store stage and the 128x32 data memory.
//  Converts byte-addressed byte/half/word requests into word-indexed memory accesses.
//  Sub-word stores use read-modify-write; sub-word loads are extracted and sign/zero extended.
//  Misaligned accesses are rejected. One request in flight; valid/ready on the CPU side.
// PARAMETERS
//  MEM_IDX_W  7   word-index bits the memory decodes (2^7 = 128 words)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   1   CPU request present
//  req_ready    out  1   controller idle, request accepted when req_valid & req_ready
//  req_we       in   1   1=store, 0=load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed   in   1   loads only: 1=sign-extend, 0=zero-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_rdata    out  32  load result (0 for stores/errors)
//  rsp_err      out  1   qualified by rsp_valid: misaligned/illegal (or out of range)
//  mem_addr     out  32  word index = {2'b00, addr[31:2]}
//  mem_din      out  32  write data to memory
//  mem_w        out  1   memory write strobe
//  mem_r        out  1   memory read strobe
//  mem_dout     in   32  memory read data, valid the cycle after mem_r
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; rsp_valid, rsp_err, mem_w, mem_r = 0; rsp_rdata, mem_addr, mem_din = 0.
//  - All outputs are registered except req_ready, which is decoded from state (1 only in IDLE).
//  - On accept, capture we/size/signed/addr/wdata. Later changes on req_* are ignored until IDLE.
//  - FSM states: IDLE, RD (mem_r=1), CAP (latch mem_dout), WR (mem_w=1), DONE (rsp_valid=1).
//    mem_r and mem_w are each high exactly one cycle per access and never high together.
//  - Load:             IDLE->RD->CAP->DONE. rsp_valid 3 cycles after the accept cycle.
//  - Word store:       IDLE->WR->DONE. rsp_valid 2 cycles after accept.
//  - Byte/half store:  IDLE->RD->CAP->WR->DONE. rsp_valid 4 cycles after accept.
//    mem_din = read word with the addressed lane(s) replaced.
//  - Error:            IDLE->DONE with rsp_err=1. No mem_r/mem_w. rsp_valid 1 cycle after accept.
//    Triggered by: half with addr[0]=1; word with addr[1:0]!=0; size=11.
//  - Lanes are little-endian. byte lane=addr[1:0] (lane 0 = bits[7:0]). half lane=addr[1] (0 = bits[15:0]).
//  - Load extension: sign bit of the selected lane when req_signed, else zero fill. Word loads pass through.
//  - DONE->IDLE unconditionally. No response backpressure.
//    A new request may be accepted in the cycle after DONE.
//  - rsp_rdata/rsp_err hold their values until the next DONE.
//    Consumers use them only while rsp_valid=1.
//  - rst_n assertion in any state: immediate return to IDLE, strobes cleared asynchronously.
//    An in-progress RMW is abandoned; memory is not written and no rsp_valid is issued.
// CONFIGURATION
//  DMEM_BOUNDS_CHK_EN defined:
//    Any request with req_addr[31:MEM_IDX_W+2] != 0 is an error.
//    Takes the error path: rsp_err=1, no memory strobe.
//  DMEM_BOUNDS_CHK_EN undefined:
//    No range check. Upper bits pass to mem_addr and the memory wraps on its low MEM_IDX_W bits.
// TESTING
//  1. Word store 0xDEADBEEF @0x40:
//     -> mem_w=1 for one cycle (cycle 1), mem_addr=0x10, mem_din=0xDEADBEEF; rsp_valid cycle 2, rsp_err=0.
//  2. Word load @0x40 after test 1:
//     -> mem_r cycle 1; rsp_valid cycle 3, rsp_rdata=0xDEADBEEF.
//  3. Byte store 0xA5 @0x41:
//     -> mem_r cycle 1, mem_w cycle 3 with mem_din=0xDEADA5EF; rsp_valid cycle 4.
//  4. Loads after test 3:
//     -> signed byte @0x41 = 0xFFFFFFA5.
//     -> unsigned byte @0x41 = 0x000000A5.
//     -> signed half @0x42 = 0xFFFFDEAD.
//     -> unsigned half @0x40 = 0x0000A5EF.
//  5. Error cases (word load @0x42, half store @0x43, size=11):
//     -> rsp_valid+rsp_err cycle 1, no mem_r/mem_w.
//     Also: rst_n pulsed low during CAP of a byte store
//     -> mem_w never asserts, word unchanged, req_ready=1 after release.
//  6. Word load @0x200:
//     -> with DMEM_BOUNDS_CHK_EN: rsp_err=1, no mem_r.
//     -> without: mem_addr=0x80, returns contents of word 0.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Bundles the CPU request/response handshake and the data-memory port of dmem_access_ctrl.
// slave = controller view, master = CPU plus memory environment view.
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_w;
  logic        mem_r;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_din, mem_w, mem_r
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_din, mem_w, mem_r
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: byte/half/word loads and stores onto a word-indexed memory,
// read-modify-write for sub-word stores. Optional macro DMEM_BOUNDS_CHK_EN adds an address range check.
module dmem_access_ctrl #(
  parameter int MEM_IDX_W = 7
) (
  input logic               clk,
  input logic               rst_n,
  dmem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic        mem_w_q, mem_w_d;
  logic        mem_r_q, mem_r_d;
  logic        bad_s;

  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] low);
    logic b;
    case (size)
      2'd0:    b = 1'b0;
      2'd1:    b = low[0];
      2'd2:    b = (low != 2'd0);
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sgn,
                                               input logic [1:0] lane, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    r = {{24{sgn & b[7]}}, b};
      2'd1:    r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [1:0] size, input logic [1:0] lane,
                                              input logic [31:0] word, input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    case (size)
      2'd0: begin
        case (lane)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      2'd1: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  // Request legality: alignment/size, plus the optional upper-address range check.
  always_comb begin
`ifdef DMEM_BOUNDS_CHK_EN
    bad_s = req_bad(bus.req_size, bus.req_addr[1:0]) |
            ((bus.req_addr >> (MEM_IDX_W + 2)) != 32'd0);
`else
    bad_s = req_bad(bus.req_size, bus.req_addr[1:0]);
`endif
  end

  // Next-state and next-output decode; strobes and rsp_valid default low so each lasts one cycle.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_w_d     = 1'b0;
    mem_r_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          lane_d   = bus.req_addr[1:0];
          wdata_d  = bus.req_wdata;
          if (bad_s) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else if (bus.req_we && (bus.req_size == 2'd2)) begin
            state_d    = S_WR;
            mem_addr_d = {2'b00, bus.req_addr[31:2]};
            mem_din_d  = bus.req_wdata;
            mem_w_d    = 1'b1;
          end else begin
            state_d    = S_RD;
            mem_addr_d = {2'b00, bus.req_addr[31:2]};
            mem_r_d    = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD:   state_d = S_CAP;
      S_CAP: begin
        // mem_dout now holds the word read in S_RD
        if (we_q) begin
          state_d   = S_WR;
          mem_din_d = store_merge(size_q, lane_q, bus.mem_dout, wdata_q);
          mem_w_d   = 1'b1;
        end else begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_extract(size_q, signed_q, lane_q, bus.mem_dout);
        end
      end
      S_WR: begin
        state_d     = S_DONE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      lane_q      <= 2'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_din_q   <= 32'd0;
      mem_w_q     <= 1'b0;
      mem_r_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_w_q     <= mem_w_d;
      mem_r_q     <= mem_r_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_w     = mem_w_q;
  assign bus.mem_r     = mem_r_q;

endmodule
